// File: rtl/spi_byte_shifter_if.sv
// rtl/spi_byte_shifter_if.sv - word handshake, analyser strobes and serial lines of spi_byte_shifter
interface spi_byte_shifter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_tx_valid;
    logic                  o_tx_ready;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic                  o_work_en;
    logic                  i_up_edge;
    logic                  i_down_edge;
    logic                  i_work_end;
    logic                  i_miso;
    logic                  o_mosi;
    logic [DATA_WIDTH-1:0] o_rx_data;
    logic                  o_rx_valid;
    logic                  o_err;
    logic                  o_busy;

    modport master (
        output i_tx_valid, i_tx_data, i_up_edge, i_down_edge, i_work_end, i_miso,
        input  o_tx_ready, o_work_en, o_mosi, o_rx_data, o_rx_valid, o_err, o_busy
    );

    modport slave (
        input  i_tx_valid, i_tx_data, i_up_edge, i_down_edge, i_work_end, i_miso,
        output o_tx_ready, o_work_en, o_mosi, o_rx_data, o_rx_valid, o_err, o_busy
    );
endinterface

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - SPI word shifter driven by analyser strobes; SPI_LSB_FIRST_EN selects LSB-first order
module spi_byte_shifter #(
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0,
    parameter int   DATA_WIDTH = 8,
    parameter int   CNT_WIDTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_byte_shifter_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [CNT_WIDTH-1:0]  bit_cnt;

    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_edge;
    logic                  shift_edge;
    logic                  cnt_full;
    logic                  tx_out_bit;
    logic [DATA_WIDTH-1:0] tx_sr_shifted;
    logic [DATA_WIDTH-1:0] rx_sr_shifted;

    assign lead_edge   = CPOL ? bus.i_down_edge : bus.i_up_edge;
    assign trail_edge  = CPOL ? bus.i_up_edge   : bus.i_down_edge;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign cnt_full    = (bit_cnt == BIT_LAST);

`ifdef SPI_LSB_FIRST_EN
    assign tx_out_bit    = tx_sr[0];
    assign tx_sr_shifted = {1'b0, tx_sr[DATA_WIDTH-1:1]};
    assign rx_sr_shifted = {bus.i_miso, rx_sr[DATA_WIDTH-1:1]};
`else
    assign tx_out_bit    = tx_sr[DATA_WIDTH-1];
    assign tx_sr_shifted = {tx_sr[DATA_WIDTH-2:0], 1'b0};
    assign rx_sr_shifted = {rx_sr[DATA_WIDTH-2:0], bus.i_miso};
`endif

    // Outputs are registered, so each transition also sets the outputs of the state it enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            tx_sr          <= '0;
            rx_sr          <= '0;
            bit_cnt        <= '0;
            bus.o_mosi     <= 1'b0;
            bus.o_rx_data  <= '0;
            bus.o_rx_valid <= 1'b0;
            bus.o_err      <= 1'b0;
            bus.o_work_en  <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_tx_ready <= 1'b1;
        end else begin
            bus.o_rx_valid <= 1'b0;
            bus.o_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_tx_valid) begin
                        tx_sr          <= bus.i_tx_data;
                        state          <= S_LOAD;
                        bus.o_tx_ready <= 1'b0;
                        bus.o_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    bit_cnt <= '0;
                    rx_sr   <= '0;
                    // With CPHA=0 the first bit must be on the line before the first sample strobe.
                    if (!CPHA) begin
                        bus.o_mosi <= tx_out_bit;
                        tx_sr      <= tx_sr_shifted;
                    end
                    bus.o_work_en <= 1'b1;
                    state         <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (cnt_full) begin
                        bus.o_rx_data  <= rx_sr;
                        bus.o_rx_valid <= 1'b1;
                        bus.o_work_en  <= 1'b0;
                        state          <= S_DONE;
                    end else if (bus.i_work_end) begin
                        bus.o_err     <= 1'b1;
                        bus.o_mosi    <= 1'b0;
                        bus.o_work_en <= 1'b0;
                        state         <= S_ABORT;
                    end else begin
                        if (sample_edge) begin
                            rx_sr   <= rx_sr_shifted;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (shift_edge) begin
                            bus.o_mosi <= tx_out_bit;
                            tx_sr      <= tx_sr_shifted;
                        end
                    end
                end
                S_DONE, S_ABORT: begin
                    bus.o_tx_ready <= 1'b1;
                    bus.o_busy     <= 1'b0;
                    state          <= S_IDLE;
                end
                default: begin
                    bus.o_work_en  <= 1'b0;
                    bus.o_tx_ready <= 1'b1;
                    bus.o_busy     <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_byte_shifter.sv
// tb/tb_spi_byte_shifter.sv - directed checks of spi_byte_shifter in CPOL0/CPHA0 and CPOL1/CPHA1 builds
module tb_spi_byte_shifter;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_byte_shifter_if #(.DATA_WIDTH(W)) bus_a ();
    spi_byte_shifter_if #(.DATA_WIDTH(W)) bus_b ();

    spi_byte_shifter #(.CPOL(1'b0), .CPHA(1'b0), .DATA_WIDTH(W), .CNT_WIDTH(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    spi_byte_shifter #(.CPOL(1'b1), .CPHA(1'b1), .DATA_WIDTH(W), .CNT_WIDTH(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_vec = 0;
    int n_bad = 0;
    int rxv_a = 0;
    int err_a = 0;
    int rxv_b = 0;
    int err_b = 0;

    always @(negedge clk) begin
        if (bus_a.o_rx_valid) rxv_a++;
        if (bus_a.o_err)      err_a++;
        if (bus_b.o_rx_valid) rxv_b++;
        if (bus_b.o_err)      err_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_a(input logic [W-1:0] data);
        check("a_ready_before_start", 32'(bus_a.o_tx_ready), 32'd1);
        bus_a.i_tx_valid = 1'b1;
        bus_a.i_tx_data  = data;
        @(negedge clk);
        bus_a.i_tx_valid = 1'b0;
        bus_a.i_tx_data  = ~data;
        @(negedge clk);
    endtask

    task automatic start_b(input logic [W-1:0] data);
        bus_b.i_tx_valid = 1'b1;
        bus_b.i_tx_data  = data;
        @(negedge clk);
        bus_b.i_tx_valid = 1'b0;
        bus_b.i_tx_data  = ~data;
        @(negedge clk);
    endtask

    // CPOL0/CPHA0: up strobe samples, down strobe shifts.
    task automatic bit_a(input logic loop, output logic seen);
        seen = bus_a.o_mosi;
        bus_a.i_miso    = loop ? bus_a.o_mosi : 1'b0;
        bus_a.i_up_edge = 1'b1;
        @(negedge clk);
        bus_a.i_up_edge   = 1'b0;
        bus_a.i_down_edge = 1'b1;
        @(negedge clk);
        bus_a.i_down_edge = 1'b0;
    endtask

    // CPOL1/CPHA1: down strobe shifts, up strobe samples.
    task automatic bit_b(output logic seen);
        bus_b.i_down_edge = 1'b1;
        @(negedge clk);
        bus_b.i_down_edge = 1'b0;
        seen = bus_b.o_mosi;
        bus_b.i_miso    = 1'b1;
        bus_b.i_up_edge = 1'b1;
        @(negedge clk);
        bus_b.i_up_edge = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] got;
        logic         s;
        logic         first_bit;
        int           rxv_snap;
        int           err_snap;

        bus_a.i_tx_valid = 1'b0; bus_a.i_tx_data = '0; bus_a.i_up_edge = 1'b0;
        bus_a.i_down_edge = 1'b0; bus_a.i_work_end = 1'b0; bus_a.i_miso = 1'b0;
        bus_b.i_tx_valid = 1'b0; bus_b.i_tx_data = '0; bus_b.i_up_edge = 1'b0;
        bus_b.i_down_edge = 1'b0; bus_b.i_work_end = 1'b0; bus_b.i_miso = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_mosi",     32'(bus_a.o_mosi),     32'd0);
        check("rst_rx_data",  32'(bus_a.o_rx_data),  32'd0);
        check("rst_rx_valid", 32'(bus_a.o_rx_valid), 32'd0);
        check("rst_err",      32'(bus_a.o_err),      32'd0);
        check("rst_work_en",  32'(bus_a.o_work_en),  32'd0);
        check("rst_busy",     32'(bus_a.o_busy),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx_ready_a", 32'(bus_a.o_tx_ready), 32'd1);
        check("rst_tx_ready_b", 32'(bus_b.o_tx_ready), 32'd1);

        // 1: CPOL0 CPHA0 loopback of A5
        start_a(8'hA5);
        check("t1_work_en", 32'(bus_a.o_work_en), 32'd1);
        check("t1_busy",    32'(bus_a.o_busy),    32'd1);
        got = '0;
        for (int i = 0; i < W; i++) begin
            bit_a(1'b1, s);
            got = {got[W-2:0], s};
        end
        check("t1_mosi_seq", 32'(got),              32'hA5);
        check("t1_rx_valid", 32'(bus_a.o_rx_valid), 32'd1);
        check("t1_rx_data",  32'(bus_a.o_rx_data),  32'hA5);
        check("t1_work_en_done", 32'(bus_a.o_work_en), 32'd0);
        check("t1_ready_done",   32'(bus_a.o_tx_ready), 32'd0);
        @(negedge clk);
        check("t1_idle_ready", 32'(bus_a.o_tx_ready), 32'd1);
        check("t1_mosi_hold",  32'(bus_a.o_mosi),     32'd1);
        // strobes in IDLE must not disturb anything
        bus_a.i_miso = 1'b0;
        bus_a.i_up_edge = 1'b1;
        bus_a.i_down_edge = 1'b1;
        repeat (3) @(negedge clk);
        bus_a.i_up_edge = 1'b0;
        bus_a.i_down_edge = 1'b0;
        @(negedge clk);
        check("t1_idle_strobe_busy", 32'(bus_a.o_busy),    32'd0);
        check("t1_idle_strobe_rx",   32'(bus_a.o_rx_data), 32'hA5);
        check("t1_idle_strobe_mosi", 32'(bus_a.o_mosi),    32'd1);
        check("t1_rxv_count", 32'(rxv_a), 32'd1);

        // 2: CPOL1 CPHA1, MISO tied high, tx 3C
        start_b(8'h3C);
        check("t2_mosi_pre", 32'(bus_b.o_mosi),    32'd0);
        check("t2_work_en",  32'(bus_b.o_work_en), 32'd1);
        got = '0;
        for (int i = 0; i < W; i++) begin
            bit_b(s);
            got = {got[W-2:0], s};
        end
        check("t2_mosi_seq", 32'(got), 32'h3C);
        @(negedge clk);
        check("t2_rx_valid", 32'(bus_b.o_rx_valid), 32'd1);
        check("t2_rx_data",  32'(bus_b.o_rx_data),  32'hFF);
        repeat (2) @(negedge clk);
        check("t2_rxv_count", 32'(rxv_b), 32'd1);
        check("t2_err_count", 32'(err_b), 32'd0);

        // 3: work_end after 5 samples aborts
        start_a(8'h5A);
        for (int i = 0; i < 5; i++) bit_a(1'b0, s);
        bus_a.i_work_end = 1'b1;
        @(negedge clk);
        bus_a.i_work_end = 1'b0;
        check("t3_err",      32'(bus_a.o_err),      32'd1);
        check("t3_rx_valid", 32'(bus_a.o_rx_valid), 32'd0);
        check("t3_mosi",     32'(bus_a.o_mosi),     32'd0);
        check("t3_work_en",  32'(bus_a.o_work_en),  32'd0);
        @(negedge clk);
        check("t3_err_clear", 32'(bus_a.o_err),      32'd0);
        check("t3_idle_busy", 32'(bus_a.o_busy),     32'd0);
        check("t3_ready",     32'(bus_a.o_tx_ready), 32'd1);
        check("t3_rx_keep",   32'(bus_a.o_rx_data),  32'hA5);
        @(negedge clk);
        check("t3_err_count", 32'(err_a), 32'd1);
        check("t3_rxv_count", 32'(rxv_a), 32'd1);

        // 4: asynchronous reset during the 4th bit
        rxv_snap = rxv_a;
        err_snap = err_a;
        start_a(8'hFF);
        for (int i = 0; i < 3; i++) bit_a(1'b0, s);
        bus_a.i_up_edge = 1'b1;
        @(negedge clk);
        bus_a.i_up_edge = 1'b0;
        check("t4_mosi_pre",    32'(bus_a.o_mosi),    32'd1);
        check("t4_work_en_pre", 32'(bus_a.o_work_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_mosi",    32'(bus_a.o_mosi),    32'd0);
        check("t4_rst_work_en", 32'(bus_a.o_work_en), 32'd0);
        check("t4_rst_busy",    32'(bus_a.o_busy),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_ready", 32'(bus_a.o_tx_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("t4_no_rxv", 32'(rxv_a), 32'(rxv_snap));
        check("t4_no_err", 32'(err_a), 32'(err_snap));

        // 5: back-to-back transfers with tx_valid held high
        bus_a.i_tx_valid = 1'b1;
        bus_a.i_tx_data  = 8'h11;
        @(negedge clk);
        bus_a.i_tx_data  = 8'h22;
        @(negedge clk);
        for (int i = 0; i < W; i++) bit_a(1'b1, s);
        check("t5_rx_valid_1", 32'(bus_a.o_rx_valid), 32'd1);
        check("t5_rx_data_1",  32'(bus_a.o_rx_data),  32'h11);
        @(negedge clk);
        check("t5_gap_ready", 32'(bus_a.o_tx_ready), 32'd1);
        check("t5_gap_busy",  32'(bus_a.o_busy),     32'd0);
        @(negedge clk);
        check("t5_accept2_busy",  32'(bus_a.o_busy),     32'd1);
        check("t5_accept2_ready", 32'(bus_a.o_tx_ready), 32'd0);
        bus_a.i_tx_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < W; i++) bit_a(1'b1, s);
        check("t5_rx_valid_2", 32'(bus_a.o_rx_valid), 32'd1);
        check("t5_rx_data_2",  32'(bus_a.o_rx_data),  32'h22);
        repeat (2) @(negedge clk);
        check("t5_rxv_count", 32'(rxv_a), 32'(rxv_snap + 2));

`ifdef SPI_LSB_FIRST_EN
        // 6: LSB-first loopback of 01
        start_a(8'h01);
        first_bit = bus_a.o_mosi;
        for (int i = 0; i < W; i++) bit_a(1'b1, s);
        check("t6_first_bit", 32'(first_bit),         32'd1);
        check("t6_rx_data",   32'(bus_a.o_rx_data),   32'h01);
        @(negedge clk);
`else
        first_bit = 1'b0;
`endif
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
